// File: rtl/fetch_pc.sv
// Fetch-stage program counter: selects the next fetch PC and presents the fetched word to F/D.
// Optional FETCH_RANGE_CHECK_EN adds a [TEXT_LO, TEXT_HI] window to the AdEL fetch check.
module fetch_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_en,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [31:0] D_PCPlus4,
  input  logic [15:0] D_Imm16,
  input  logic [25:0] D_Imm26,
  input  logic [31:0] D_RsData,
  input  logic        D_IsJump,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_Ins,
  output logic [31:0] F_PCAddr,
  output logic [31:0] F_PCPlus4,
  output logic [4:0]  F_ExcCode,
  output logic        F_BD
);

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JREG   = 2'd3;
  localparam logic [4:0] EXC_NONE   = 5'd0;
  localparam logic [4:0] EXC_ADEL   = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_redirect_pc;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_adel;

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm16);
    logic signed [31:0] off;
    off = {{14{imm16[15]}}, imm16, 2'b00};
    return pc_plus4 + off;
  endfunction

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = branch_target(D_PCPlus4, D_Imm16);
  assign w_j_target  = {D_PCPlus4[31:28], D_Imm26, 2'b00};

  // Redirect choice below stall/req; eret has no delay slot and outranks the D-stage jump decode.
  always_comb begin
    w_redirect_pc = w_pc_plus4;
    if (eret_en) begin
      w_redirect_pc = epc;
    end else begin
      case (npc_sel)
        NPC_JREG:   w_redirect_pc = D_RsData;
        NPC_JUMP:   w_redirect_pc = w_j_target;
        NPC_BRANCH: w_redirect_pc = branch_taken ? w_br_target : w_pc_plus4;
        default:    w_redirect_pc = w_pc_plus4;
      endcase
    end
  end

  // PC register: reset > exception entry > stall hold > redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (req) begin
      r_pc <= EXC_ENTRY;
    end else if (!stall) begin
      r_pc <= w_redirect_pc;
    end
  end

  assign w_misaligned = (r_pc[1:0] != 2'b00);
`ifdef FETCH_RANGE_CHECK_EN
  assign w_out_of_range = (r_pc < TEXT_LO) || (r_pc > TEXT_HI);
`else
  assign w_out_of_range = 1'b0;
`endif
  assign w_adel = w_misaligned || w_out_of_range;

  assign i_inst_addr = r_pc;
  assign F_PCAddr    = r_pc;
  assign F_PCPlus4   = w_pc_plus4;
  assign F_ExcCode   = w_adel ? EXC_ADEL : EXC_NONE;
  assign F_Ins       = (w_adel || eret_en) ? 32'd0 : i_inst_rdata;
  assign F_BD        = D_IsJump & ~eret_en;

endmodule

// File: tb/tb_fetch_pc.sv
// Bench for fetch_pc: directed scenarios plus randomized cycles against a behavioural PC model.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret_en, branch_taken, D_IsJump;
  logic [31:0] epc, D_PCPlus4, D_RsData;
  logic [1:0]  npc_sel;
  logic [15:0] D_Imm16;
  logic [25:0] D_Imm26;
  logic [31:0] i_inst_rdata, i_inst_addr, F_Ins, F_PCAddr, F_PCPlus4;
  logic [4:0]  F_ExcCode;
  logic        F_BD;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;

`ifdef FETCH_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hBEEF};
  endfunction

  assign i_inst_rdata = imem(i_inst_addr);

  fetch_pc dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret_en(eret_en), .epc(epc),
    .npc_sel(npc_sel), .branch_taken(branch_taken), .D_PCPlus4(D_PCPlus4),
    .D_Imm16(D_Imm16), .D_Imm26(D_Imm26), .D_RsData(D_RsData), .D_IsJump(D_IsJump),
    .i_inst_rdata(i_inst_rdata), .i_inst_addr(i_inst_addr), .F_Ins(F_Ins),
    .F_PCAddr(F_PCAddr), .F_PCPlus4(F_PCPlus4), .F_ExcCode(F_ExcCode), .F_BD(F_BD)
  );

  function automatic bit model_adel(input logic [31:0] pc);
    bit bad;
    bad = (pc % 4) != 0;
    if (RANGE_CHK && (pc < 32'h3000 || pc > 32'h6FFC)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_npc();
    int off;
    if (reset) return 32'h3000;
    if (req) return 32'h4180;
    if (stall) return m_pc;
    if (eret_en) return epc;
    if (npc_sel == 2'd3) return D_RsData;
    if (npc_sel == 2'd2) return (D_PCPlus4 & 32'hF000_0000) | (32'(D_Imm26) * 4);
    if (npc_sel == 2'd1 && branch_taken) begin
      off = int'($signed(D_Imm16));
      return D_PCPlus4 + 32'(off * 4);
    end
    return m_pc + 4;
  endfunction

  task automatic idle_inputs();
    reset = 0; stall = 0; req = 0; eret_en = 0; epc = 0; npc_sel = 0; branch_taken = 0;
    D_PCPlus4 = 0; D_Imm16 = 0; D_Imm26 = 0; D_RsData = 0; D_IsJump = 0;
  endtask

  task automatic advance();
    logic [31:0] nxt;
    nxt = model_npc();
    @(posedge clk);
    #1;
    m_pc = nxt;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; D_IsJump = 1;
    advance();
    reset = 0;
    #1;
    checks++; if (F_PCAddr !== 32'h3000) begin errors++; $display("FAIL reset_pc actual=%h required=%h", F_PCAddr, 32'h3000); end
    checks++; if (i_inst_addr !== 32'h3000) begin errors++; $display("FAIL reset_iaddr actual=%h required=%h", i_inst_addr, 32'h3000); end
    checks++; if (F_PCPlus4 !== 32'h3004) begin errors++; $display("FAIL reset_pcp4 actual=%h required=%h", F_PCPlus4, 32'h3004); end
    checks++; if (F_ExcCode !== 5'd0) begin errors++; $display("FAIL reset_exc actual=%0d required=0", F_ExcCode); end
    checks++; if (F_BD !== 1'b1) begin errors++; $display("FAIL reset_bd actual=%b required=1", F_BD); end
    checks++; if (F_Ins !== imem(32'h3000)) begin errors++; $display("FAIL reset_ins actual=%h required=%h", F_Ins, imem(32'h3000)); end
    D_IsJump = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      advance();
      exp_pc = 32'h3000 + 32'(4 * i);
      checks++; if (F_PCAddr !== exp_pc) begin errors++; $display("FAIL seq_pc%0d actual=%h required=%h", i, F_PCAddr, exp_pc); end
      checks++; if (F_ExcCode !== 5'd0) begin errors++; $display("FAIL seq_exc%0d actual=%0d required=0", i, F_ExcCode); end
    end
  endtask

  task automatic test_branch();
    npc_sel = 2'd1; branch_taken = 1; D_PCPlus4 = 32'h3008; D_Imm16 = 16'hFFFE; D_IsJump = 1;
    #1;
    checks++; if (F_BD !== 1'b1) begin errors++; $display("FAIL branch_bd actual=%b required=1", F_BD); end
    advance();
    idle_inputs();
    checks++; if (F_PCAddr !== 32'h3000) begin errors++; $display("FAIL branch_pc actual=%h required=%h", F_PCAddr, 32'h3000); end
  endtask

  task automatic test_jr_adel();
    logic [4:0] exp_exc;
    npc_sel = 2'd3; D_RsData = 32'h3001;
    advance();
    idle_inputs();
    #1;
    checks++; if (F_PCAddr !== 32'h3001) begin errors++; $display("FAIL jr_pc actual=%h required=%h", F_PCAddr, 32'h3001); end
    checks++; if (F_ExcCode !== 5'd4) begin errors++; $display("FAIL jr_mis_exc actual=%0d required=4", F_ExcCode); end
    checks++; if (F_Ins !== 32'd0) begin errors++; $display("FAIL jr_mis_ins actual=%h required=0", F_Ins); end
    npc_sel = 2'd3; D_RsData = 32'h8000;
    advance();
    idle_inputs();
    #1;
    exp_exc = RANGE_CHK ? 5'd4 : 5'd0;
    checks++; if (F_ExcCode !== exp_exc) begin errors++; $display("FAIL jr_range_exc actual=%0d required=%0d", F_ExcCode, exp_exc); end
    checks++; if (F_Ins !== (RANGE_CHK ? 32'd0 : imem(32'h8000))) begin errors++; $display("FAIL jr_range_ins actual=%h", F_Ins); end
  endtask

  task automatic test_stall_jump();
    npc_sel = 2'd3; D_RsData = 32'h3010;
    advance();
    idle_inputs();
    stall = 1; npc_sel = 2'd2; D_PCPlus4 = 32'h3014; D_Imm26 = 26'h0000123;
    for (int i = 0; i < 2; i++) begin
      advance();
      checks++; if (F_PCAddr !== 32'h3010) begin errors++; $display("FAIL stall_hold%0d actual=%h required=%h", i, F_PCAddr, 32'h3010); end
    end
    stall = 0; D_Imm26 = 26'h0000C10;
    advance();
    idle_inputs();
    checks++; if (F_PCAddr !== 32'h3040) begin errors++; $display("FAIL jump_pc actual=%h required=%h", F_PCAddr, 32'h3040); end
  endtask

  task automatic test_req_eret();
    req = 1; stall = 1; npc_sel = 2'd3; D_RsData = 32'h5000;
    advance();
    idle_inputs();
    checks++; if (F_PCAddr !== 32'h4180) begin errors++; $display("FAIL req_pc actual=%h required=%h", F_PCAddr, 32'h4180); end
    eret_en = 1; epc = 32'h3024; D_IsJump = 1; npc_sel = 2'd3; D_RsData = 32'h5000;
    #1;
    checks++; if (F_Ins !== 32'd0) begin errors++; $display("FAIL eret_ins actual=%h required=0", F_Ins); end
    checks++; if (F_BD !== 1'b0) begin errors++; $display("FAIL eret_bd actual=%b required=0", F_BD); end
    advance();
    idle_inputs();
    checks++; if (F_PCAddr !== 32'h3024) begin errors++; $display("FAIL eret_pc actual=%h required=%h", F_PCAddr, 32'h3024); end
  endtask

  task automatic test_reset_override();
    reset = 1; eret_en = 1; req = 1; stall = 1; epc = 32'h3100;
    advance();
    idle_inputs();
    checks++; if (F_PCAddr !== 32'h3000) begin errors++; $display("FAIL reset_override actual=%h required=%h", F_PCAddr, 32'h3000); end
  endtask

  task automatic test_random();
    logic [31:0] exp_ins;
    logic [4:0]  exp_exc;
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 40) == 0);
      req          = ($urandom_range(0, 15) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      eret_en      = ($urandom_range(0, 7) == 0);
      npc_sel      = 2'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
      D_IsJump     = 1'($urandom_range(0, 1));
      D_PCPlus4    = m_pc + 32'(4 * $urandom_range(0, 4));
      D_Imm16      = 16'($urandom_range(0, 64)) - 16'd32;
      D_Imm26      = 26'($urandom_range(32'hBF0, 32'h1C10));
      epc          = 32'($urandom_range(32'h2FF0, 32'h7010)) & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      D_RsData     = 32'($urandom_range(32'h2FF0, 32'h7010)) & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      #1;
      exp_exc = model_adel(m_pc) ? 5'd4 : 5'd0;
      exp_ins = (model_adel(m_pc) || eret_en) ? 32'd0 : imem(m_pc);
      checks++; if (F_PCAddr !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] actual=%h required=%h", n, F_PCAddr, m_pc); end
      checks++; if (F_PCPlus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pcp4[%0d] actual=%h required=%h", n, F_PCPlus4, m_pc + 32'd4); end
      checks++; if (F_ExcCode !== exp_exc) begin errors++; $display("FAIL rnd_exc[%0d] actual=%0d required=%0d", n, F_ExcCode, exp_exc); end
      checks++; if (F_Ins !== exp_ins) begin errors++; $display("FAIL rnd_ins[%0d] actual=%h required=%h", n, F_Ins, exp_ins); end
      checks++; if (F_BD !== (D_IsJump && !eret_en)) begin errors++; $display("FAIL rnd_bd[%0d] actual=%b required=%b", n, F_BD, D_IsJump && !eret_en); end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pc = 32'h3000;
    test_reset();
    test_sequential();
    test_branch();
    test_jr_adel();
    test_stall_jump();
    test_req_eret();
    test_reset_override();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Fetch-stage program counter unit: holds the architectural fetch PC, computes the next PC from D-stage control-flow results, and presents the fetched instruction with its PC, PC+4, exception code and delay-slot flag to the F/D pipeline register. It sits directly upstream of the F/D register. It drives the instruction-memory address and consumes its read data. It also takes the exception-entry request and the `eret` redirect from the CP0/exception logic.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_ENTRY, 32'h0000_4180, handler entry address on req
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall; hold PC
- req  in  1  exception/interrupt taken this cycle
- eret_en  in  1  D-stage instruction is eret
- epc  in  32  return address from CP0, already forwarded
- npc_sel  in  2  0 = sequential, 1 = branch, 2 = j/jal, 3 = jr/jalr
- branch_taken  in  1  branch condition result (used only when npc_sel = 1)
- D_PCPlus4  in  32  PC+4 of the D-stage instruction
- D_Imm16  in  16  branch offset field
- D_Imm26  in  26  jump index field
- D_RsData  in  32  forwarded rs value for jr
- D_IsJump  in  1  D-stage instruction is a branch or jump (next F instruction is its delay slot)
- i_inst_rdata  in  32  instruction-memory read data (combinational on i_inst_addr)
- i_inst_addr  out  32  instruction-memory address (= PC)
- F_Ins  out  32  fetched instruction, or 0 when squashed
- F_PCAddr  out  32  current PC
- F_PCPlus4  out  32  PC + 4
- F_ExcCode  out  5  0 = none, 4 = AdEL
- F_BD  out  1  fetched instruction is in a delay slot

## Operation
- The only state is the PC register. All other outputs are combinational from PC and inputs.
- Next-PC priority, highest first:
  - reset → RESET_PC
  - req → EXC_ENTRY
  - stall → hold PC
  - eret_en → epc
  - npc_sel = 3 → D_RsData
  - npc_sel = 2 → {D_PCPlus4[31:28], D_Imm26, 2'b00}
  - npc_sel = 1 and branch_taken → D_PCPlus4 + (sign-extended D_Imm16 << 2)
  - otherwise → PC + 4
- Arithmetic is 32-bit modulo 2^32. Wrap-around is not trapped; the resulting address is caught by the range check.
- F_PCPlus4 = PC + 4.
- F_BD = D_IsJump & ~eret_en.
- Address check: AdEL (ExcCode 4) when PC[1:0] ≠ 0, or when PC < TEXT_LO or PC > TEXT_HI. See Configuration for the range check.
- F_Ins = 0 when AdEL is flagged or when eret_en = 1. eret has no delay slot, so the instruction behind it is squashed to a nop. Otherwise F_Ins = i_inst_rdata.
- F_ExcCode = 4 on AdEL, else 0. It is still reported during eret_en.

## Timing
- Reset values:
  - PC = 32'h3000, so F_PCAddr = i_inst_addr = 32'h3000
  - F_PCPlus4 = 32'h3004
  - F_ExcCode = 0
  - F_BD = D_IsJump
  - F_Ins = i_inst_rdata
- Latency: the redirect decided in cycle N is visible on F_PCAddr in cycle N+1.
- req overrides stall in the same cycle. The PC loads EXC_ENTRY even while stalled.
- stall with eret_en or any npc_sel: the PC holds. The redirect is re-evaluated next cycle because D holds too. No redirect is latched internally.
- reset asserted mid-stream wins over req, stall and any redirect.

## Configuration
- FETCH_RANGE_CHECK_EN defined: AdEL is flagged for misalignment OR an address outside [TEXT_LO, TEXT_HI].
- FETCH_RANGE_CHECK_EN undefined: only PC[1:0] ≠ 0 raises AdEL. Out-of-range aligned addresses fetch normally.

## Test plan
- Reset, then 3 free-running cycles → F_PCAddr 3000, 3004, 3008, 300C; F_ExcCode = 0.
- beq in D with D_PCPlus4 = 3008, D_Imm16 = 16'hFFFE, taken, D_IsJump = 1 → F_BD = 1 this cycle; next F_PCAddr = 3000.
- jr with D_RsData = 32'h3001 → next cycle F_ExcCode = 4, F_Ins = 0. Repeat with 32'h8000: AdEL only if FETCH_RANGE_CHECK_EN is defined.
- stall = 1 together with npc_sel = 2 for 2 cycles → PC held at 3010. Release stall with D_Imm26 = 26'h0000C10 → next PC = 3040.
- req = 1 while stall = 1 → next PC = 4180. eret_en = 1, epc = 3024 → F_Ins = 0, F_BD = 0 that cycle; next PC = 3024.
- reset asserted while eret_en = 1 and req = 1 → next PC = 3000.
